// File: rtl/pixel_write_queue_pkg.sv
// Shared screen geometry, framebuffer sizing and FSM state encoding for the
// pixel write queue.
package pixel_write_queue_pkg;

  localparam int unsigned SCR_WIDTH       = 160;
  localparam int unsigned SCR_HEIGHT      = 120;
  localparam int unsigned SCR_WIDTH_BITS  = 8;
  localparam int unsigned SCR_HEIGHT_BITS = 7;
  localparam int unsigned COLOR_SIZE      = 3;
  localparam int unsigned FB_ADDR_BITS    = 15;
  localparam int unsigned FIFO_DEPTH      = 8;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } wq_state_e;

endpackage

// File: rtl/pixel_write_queue_fifo.sv
// Synchronous FIFO holding packed {x, y, colour} pixel requests; head is
// presented combinationally on rdata_o.
module pixel_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             Clck,
  input  logic             Reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge Clck) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_write_queue.sv
// Captures painter pixel requests into a FIFO and drains them to the video
// memory write port as linear addresses; also runs a full-screen clear.
module pixel_write_queue #(
  parameter int unsigned SCR_WIDTH  = pixel_write_queue_pkg::SCR_WIDTH,
  parameter int unsigned SCR_HEIGHT = pixel_write_queue_pkg::SCR_HEIGHT,
  parameter int unsigned X_BITS     = pixel_write_queue_pkg::SCR_WIDTH_BITS,
  parameter int unsigned Y_BITS     = pixel_write_queue_pkg::SCR_HEIGHT_BITS,
  parameter int unsigned COLOR_SIZE = pixel_write_queue_pkg::COLOR_SIZE,
  parameter int unsigned ADDR_BITS  = pixel_write_queue_pkg::FB_ADDR_BITS,
  parameter int unsigned DEPTH      = pixel_write_queue_pkg::FIFO_DEPTH
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic [X_BITS-1:0]     paint_x_co,
  input  logic [Y_BITS-1:0]     paint_y_co,
  input  logic [COLOR_SIZE-1:0] color,
  input  logic                  print_enable,
  input  logic                  clear_req,
  input  logic [COLOR_SIZE-1:0] clear_color,
  input  logic                  mem_busy,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [COLOR_SIZE-1:0] mem_data,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  overflow,
  output logic                  out_of_range
);
  import pixel_write_queue_pkg::*;

  localparam int unsigned W  = X_BITS + Y_BITS + COLOR_SIZE;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [X_BITS:0]    X_LIM    = (X_BITS + 1)'(SCR_WIDTH);
  localparam logic [Y_BITS:0]    Y_LIM    = (Y_BITS + 1)'(SCR_HEIGHT);
  localparam logic [ADDR_BITS-1:0] CLR_LAST = ADDR_BITS'(SCR_WIDTH * SCR_HEIGHT - 1);

  wq_state_e             state_q, state_d;
  logic                  pe_q;
  logic [ADDR_BITS-1:0]  clr_addr_q;
  logic [COLOR_SIZE-1:0] clr_color_q;
  logic [ADDR_BITS-1:0]  mem_addr_q;
  logic [COLOR_SIZE-1:0] mem_data_q;
  logic                  mem_we_q, busy_q, overflow_q, oor_q;

  logic                  rise, in_range, push, pop, full, empty;
  logic [W-1:0]          head;
  logic [X_BITS-1:0]     head_x;
  logic [Y_BITS-1:0]     head_y;
  logic [COLOR_SIZE-1:0] head_c;
  logic [ADDR_BITS-1:0]  head_addr;
  logic [CW-1:0]         count, count_d;

  assign rise     = print_enable & ~pe_q;
  assign in_range = ({1'b0, paint_x_co} < X_LIM) && ({1'b0, paint_y_co} < Y_LIM);
  // Range is judged first so an out-of-range request never counts as overflow.
  assign push     = rise & in_range & ~full;
  assign pop      = (state_q == RUN) & ~empty & ~mem_busy;

  pixel_fifo #(.WIDTH(W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .Clck    (Clck),
    .Reset   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({paint_x_co, paint_y_co, color}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign {head_x, head_y, head_c} = head;
  assign head_addr = ADDR_BITS'(head_y) * ADDR_BITS'(SCR_WIDTH) + ADDR_BITS'(head_x);
  assign count_d   = count + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:   if (clear_req) state_d = CLEAR;
      CLEAR: if (!mem_busy && clr_addr_q == CLR_LAST) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      state_q     <= RUN;
      pe_q        <= 1'b0;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      pe_q     <= print_enable;
      busy_q   <= (state_d == CLEAR) || (count_d != '0);
      mem_we_q <= 1'b0;
      if (rise && !in_range)        oor_q      <= 1'b1;
      if (rise && in_range && full) overflow_q <= 1'b1;
      case (state_q)
        RUN: begin
          if (pop) begin
            mem_addr_q <= head_addr;
            mem_data_q <= head_c;
            mem_we_q   <= 1'b1;
          end
          if (clear_req) begin
            clr_addr_q  <= '0;
            clr_color_q <= clear_color;
          end
        end
        CLEAR: begin
          if (!mem_busy) begin
            mem_addr_q <= clr_addr_q;
            mem_data_q <= clr_color_q;
            mem_we_q   <= 1'b1;
            clr_addr_q <= clr_addr_q + ADDR_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign mem_we       = mem_we_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue: capture, overflow, range, clear,
// back-pressure and asynchronous reset.
module tb_pixel_write_queue;
  import pixel_write_queue_pkg::*;

  logic        Clck = 1'b0;
  logic        Reset;
  logic [7:0]  paint_x_co;
  logic [6:0]  paint_y_co;
  logic [2:0]  color;
  logic        print_enable;
  logic        clear_req;
  logic [2:0]  clear_color;
  logic        mem_busy;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        busy;
  logic        overflow;
  logic        out_of_range;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [17:0] wq[$];

  pixel_write_queue dut (
    .Clck         (Clck),
    .Reset        (Reset),
    .paint_x_co   (paint_x_co),
    .paint_y_co   (paint_y_co),
    .color        (color),
    .print_enable (print_enable),
    .clear_req    (clear_req),
    .clear_color  (clear_color),
    .mem_busy     (mem_busy),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .busy         (busy),
    .overflow     (overflow),
    .out_of_range (out_of_range)
  );

  always #5 Clck = ~Clck;

  // Each write strobe lasts exactly one cycle, so a negedge sample sees it once.
  always @(negedge Clck) begin
    if (Reset === 1'b1 && mem_we === 1'b1) wq.push_back({mem_addr, mem_data});
  end

  task automatic tick();
    @(posedge Clck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                       input int unsigned hi);
    paint_x_co = x; paint_y_co = y; color = c; print_enable = 1'b1;
    repeat (hi) tick();
    print_enable = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while ((busy !== 1'b0 || mem_we !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int unsigned bad;
    int unsigned n;
    logic b;

    Reset = 1'b0; paint_x_co = '0; paint_y_co = '0; color = '0; print_enable = 1'b0;
    clear_req = 1'b0; clear_color = '0; mem_busy = 1'b0;
    repeat (2) tick();
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_oor", 32'(out_of_range), 0);
    Reset = 1'b1;
    tick();

    // 1) held print_enable -> one write, one cycle after capture
    paint_x_co = 8'd5; paint_y_co = 7'd2; color = 3'b110; print_enable = 1'b1;
    tick();
    chk("t1_we_capture", 32'(mem_we), 0);
    chk("t1_busy_capture", 32'(busy), 1);
    tick();
    chk("t1_we", 32'(mem_we), 1);
    chk("t1_addr", 32'(mem_addr), 325);
    chk("t1_data", 32'(mem_data), 6);
    tick();
    chk("t1_we_after", 32'(mem_we), 0);
    print_enable = 1'b0;
    repeat (3) tick();
    chk("t1_nwrites", wq.size(), 1);
    chk("t1_busy_end", 32'(busy), 0);
    wq.delete();

    // 2) overflow under back-pressure, then in-order drain
    mem_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("t2_ovf_at8", 32'(overflow), 0);
      pulse(8'(i), 7'(i), 3'(i), 1);
    end
    chk("t2_count", 32'(dut.count), 8);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_nowrites", wq.size(), 0);
    mem_busy = 1'b0;
    repeat (12) tick();
    chk("t2_nwrites", wq.size(), 8);
    bad = 0;
    for (int i = 0; i < 8 && i < wq.size(); i++)
      if (wq[i] !== {15'(i * 160 + i), 3'(i)}) bad++;
    chk("t2_order", bad, 0);
    chk("t2_busy_end", 32'(busy), 0);
    wq.delete();

    // 3) out-of-range requests
    pulse(8'd160, 7'd0, 3'd2, 1);
    pulse(8'd0, 7'd120, 3'd2, 1);
    repeat (3) tick();
    chk("t3_oor", 32'(out_of_range), 1);
    chk("t3_count", 32'(dut.count), 0);
    chk("t3_nowrites", wq.size(), 0);

    // 4) full-screen clear with a pixel queued mid-clear
    clear_color = 3'b001; clear_req = 1'b1;
    tick();
    clear_req = 1'b0; clear_color = 3'b000;
    chk("t4_busy", 32'(busy), 1);
    repeat (50) tick();
    pulse(8'd0, 7'd0, 3'd5, 1);
    repeat (50) tick();
    clear_color = 3'b010; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_idle("t4_timeout", 20000);
    repeat (2) tick();
    chk("t4_nwrites", wq.size(), 19201);
    bad = 0;
    for (int i = 0; i < 19200 && i < wq.size(); i++)
      if (wq[i] !== {15'(i), 3'd1}) bad++;
    chk("t4_clear_data", bad, 0);
    if (wq.size() == 19201) chk("t4_pixel_last", 32'(wq[19200]), 32'({15'd0, 3'd5}));
    else chk("t4_pixel_last", 32'(wq.size()), 19201);
    chk("t4_busy_end", 32'(busy), 0);
    wq.delete();

    // 5) back-pressure toggling every cycle during drain
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) pulse(8'(10 + i), 7'd3, 3'(i + 1), 1);
    chk("t5_count", 32'(dut.count), 4);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      mem_busy = (k % 2 == 1);
      b = mem_busy;
      tick();
      if (mem_we === 1'b1 && b) bad++;
    end
    mem_busy = 1'b0;
    repeat (2) tick();
    chk("t5_busy_cycle_writes", bad, 0);
    chk("t5_nwrites", wq.size(), 4);
    bad = 0;
    for (int i = 0; i < 4 && i < wq.size(); i++)
      if (wq[i] !== {15'(490 + i), 3'(i + 1)}) bad++;
    chk("t5_order", bad, 0);
    wq.delete();

    // 6) asynchronous reset in the middle of a clear
    clear_color = 3'b111; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    pulse(8'd1, 7'd1, 3'd2, 1);
    chk("t6_pre_count", 32'(dut.count), 1);
    n = 0;
    while (dut.clr_addr_q !== 15'd500 && n < 2000) begin
      tick();
      n++;
    end
    chk("t6_reach500", 32'(n < 2000), 1);
    #2 Reset = 1'b0;
    #1;
    chk("t6_we", 32'(mem_we), 0);
    chk("t6_addr", 32'(mem_addr), 0);
    chk("t6_data", 32'(mem_data), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_oor", 32'(out_of_range), 0);
    chk("t6_count", 32'(dut.count), 0);
    chk("t6_state", 32'(dut.state_q === RUN), 1);
    #3 Reset = 1'b1;
    tick();
    wq.delete();
    pulse(8'd7, 7'd4, 3'd3, 1);
    wait_idle("t6_timeout", 50);
    repeat (2) tick();
    chk("t6_nwrites", wq.size(), 1);
    if (wq.size() == 1) chk("t6_write", 32'(wq[0]), 32'({15'd647, 3'd3}));
    else chk("t6_write", 32'(wq.size()), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
